// File: rtl/truth_table_sweeper.sv
// Purpose : exhaustive stimulus/response sweeper for a small combinational block;
//           drives every N_IN-bit vector, samples a 1-bit response, builds the
//           captured truth table and compares it against EXPECT.
// Latency : each vector is held SETTLE+1 cycles in HOLD plus 1 cycle in SAMPLE;
//           busy lasts 2**N_IN*(SETTLE+2) cycles, and done pulses the cycle after.
// Backpressure: none; start is ignored while a sweep or its DONE cycle is in
//           progress (no queuing), and abort ends a sweep with partial results kept.
//
// Ports:
//   clock, reset_b     : clock and asynchronous active-low reset
//   start, abort       : begin a sweep (from IDLE only) / terminate a running sweep
//   resp               : response of the block under test
//   vec                : applied input vector (bit N_IN-1 is the first-listed input)
//   busy, done         : sweep in progress / one-cycle completion pulse
//   aborted            : sticky abort flag, cleared by the next accepted start
//   resp_table         : captured responses, bit i = resp sampled for vec==i
//   err_count          : mismatches against EXPECT
//   first_err          : first mismatching index, valid when err_count != 0
//   pass               : set at completion iff err_count==0
module truth_table_sweeper #(
    parameter int                     N_IN   = 5,
    parameter int                     SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]   EXPECT = 32'hA8A8A800
) (
    input  logic                   clock,
    input  logic                   reset_b,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   resp,
    output logic [N_IN-1:0]        vec,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [(1<<N_IN)-1:0]   resp_table,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_err,
    output logic                   pass
);

    localparam int              CW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic          mismatch;

    assign mismatch = (resp != EXPECT[vec]);

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            resp_table <= '0;
            err_count  <= '0;
            first_err  <= '0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= HOLD;
                        busy       <= 1'b1;
                        vec        <= '0;
                        hold_cnt   <= '0;
                        resp_table <= '0;
                        err_count  <= '0;
                        first_err  <= '0;
                        aborted    <= 1'b0;
                        pass       <= 1'b0;
                    end
                end

                HOLD: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        vec     <= '0;
                        pass    <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == SETTLE_C) begin
                            state <= SAMPLE;
                        end
                    end
                end

                SAMPLE: begin
                    // abort takes priority over the sample, including the last one
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        vec     <= '0;
                        pass    <= 1'b0;
                    end else begin
                        resp_table[vec] <= resp;
                        if (mismatch) begin
                            // cannot wrap: at most 2**N_IN mismatches fit in N_IN+1 bits
                            err_count <= err_count + 1'b1;
                            if (err_count == '0) begin
                                first_err <= vec;
                            end
                        end
                        if (vec == LAST_VEC) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // err_count has not yet absorbed this sample's mismatch
                            pass  <= (err_count == '0) && !mismatch;
                        end else begin
                            state    <= HOLD;
                            vec      <= vec + 1'b1;
                            hold_cnt <= '0;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic        clock;
    logic        reset_b;
    logic        start, abort, resp;
    logic [4:0]  vec;
    logic        busy, done, aborted, pass;
    logic [31:0] resp_table;
    logic [5:0]  err_count;
    logic [4:0]  first_err;

    // second instance built with SETTLE=0
    logic        s0_start, s0_resp;
    logic [4:0]  s0_vec;
    logic        s0_busy, s0_done, s0_aborted, s0_pass;
    logic [31:0] s0_table;
    logic [5:0]  s0_err;
    logic [4:0]  s0_first;

    int tests = 0;
    int fails = 0;
    int mode  = 0;   // 0: F, 1: stuck 0, 2: F with vec 19 inverted, 3: stuck 1

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic f_ref(input logic [4:0] v);
        return (v[4] | v[3]) & (v[2] | v[1]) & v[0];
    endfunction

    assign resp = (mode == 0) ? f_ref(vec) :
                  (mode == 1) ? 1'b0 :
                  (mode == 2) ? (f_ref(vec) ^ (vec == 5'd19)) : 1'b1;
    assign s0_resp = f_ref(s0_vec);

    truth_table_sweeper #(.N_IN(5), .SETTLE(2), .EXPECT(32'hA8A8A800)) dut (
        .clock(clock), .reset_b(reset_b), .start(start), .abort(abort), .resp(resp),
        .vec(vec), .busy(busy), .done(done), .aborted(aborted), .resp_table(resp_table),
        .err_count(err_count), .first_err(first_err), .pass(pass)
    );

    truth_table_sweeper #(.N_IN(5), .SETTLE(0), .EXPECT(32'hA8A8A800)) dut_s0 (
        .clock(clock), .reset_b(reset_b), .start(s0_start), .abort(1'b0), .resp(s0_resp),
        .vec(s0_vec), .busy(s0_busy), .done(s0_done), .aborted(s0_aborted), .resp_table(s0_table),
        .err_count(s0_err), .first_err(s0_first), .pass(s0_pass)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          mode;
        bit          inject;     // pulse start while busy and during done
        logic [31:0] tbl;
        int          err;
        int          first;
        bit          pass;
    } vec_t;

    vec_t vt[4];

    // Pulse start, then watch a fixed window; leaves the bench at a negedge.
    task automatic do_sweep(input bit inject, output int bcyc, output int dcnt);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        bcyc = 0;
        dcnt = 0;
        for (int i = 0; i < 136; i++) begin
            if (busy) bcyc++;
            if (done) begin
                dcnt++;
                if (inject) start = 1'b1;
            end
            if (inject && i == 50) start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
    endtask

    initial begin
        int bcyc, dcnt;
        start = 0; abort = 0; s0_start = 0; reset_b = 0;

        vt[0] = '{mode: 0, inject: 0, tbl: 32'hA8A8A800, err: 0, first: 0,  pass: 1};
        vt[1] = '{mode: 1, inject: 0, tbl: 32'h00000000, err: 9, first: 11, pass: 0};
        vt[2] = '{mode: 2, inject: 0, tbl: 32'hA8A0A800, err: 1, first: 19, pass: 0};
        vt[3] = '{mode: 0, inject: 1, tbl: 32'hA8A8A800, err: 0, first: 0,  pass: 1};

        #12;
        chk("reset_vec", {59'd0, vec}, 64'd0);
        chk("reset_flags", {60'd0, busy, done, aborted, pass}, 64'd0);
        chk("reset_table", {32'd0, resp_table}, 64'd0);
        chk("reset_err", {58'd0, err_count}, 64'd0);
        @(negedge clock) reset_b = 1'b1;

        for (int k = 0; k < 4; k++) begin
            mode = vt[k].mode;
            do_sweep(vt[k].inject, bcyc, dcnt);
            chk($sformatf("v%0d_busy_cycles", k), 64'(bcyc), 64'd128);
            chk($sformatf("v%0d_done_pulses", k), 64'(dcnt), 64'd1);
            chk($sformatf("v%0d_table", k), {32'd0, resp_table}, {32'd0, vt[k].tbl});
            chk($sformatf("v%0d_err", k), {58'd0, err_count}, 64'(vt[k].err));
            chk($sformatf("v%0d_first", k), {59'd0, first_err}, 64'(vt[k].first));
            chk($sformatf("v%0d_pass", k), {63'd0, pass}, {63'd0, vt[k].pass});
            chk($sformatf("v%0d_idle", k), {62'd0, busy, aborted}, 64'd0);
            chk($sformatf("v%0d_vec_held", k), {59'd0, vec}, 64'd31);
        end

        // abort during vec 5 SAMPLE (cycle 23 after start), resp stuck at 1
        mode = 3;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (23) @(negedge clock);
        chk("abort_vec_before", {59'd0, vec}, 64'd5);
        abort = 1'b1;
        @(negedge clock) abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_aborted", {63'd0, aborted}, 64'd1);
        chk("abort_vec", {59'd0, vec}, 64'd0);
        chk("abort_table", {32'd0, resp_table}, 64'h1F);
        chk("abort_err", {58'd0, err_count}, 64'd5);
        chk("abort_first", {59'd0, first_err}, 64'd0);
        chk("abort_pass", {63'd0, pass}, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 110; i++) begin
            if (done || busy) dcnt++;
            @(negedge clock);
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);

        // reset mid-sweep at vec 17, then a full sweep must be clean
        mode = 0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (68) @(negedge clock);
        chk("rst_vec_before", {59'd0, vec}, 64'd17);
        #2 reset_b = 1'b0;
        #1;
        chk("rst_async_vec", {59'd0, vec}, 64'd0);
        chk("rst_async_flags", {60'd0, busy, done, aborted, pass}, 64'd0);
        chk("rst_async_table", {32'd0, resp_table}, 64'd0);
        chk("rst_async_err", {53'd0, err_count, first_err}, 64'd0);
        @(negedge clock) reset_b = 1'b1;
        do_sweep(1'b0, bcyc, dcnt);
        chk("rst_resweep_busy", 64'(bcyc), 64'd128);
        chk("rst_resweep_table", {32'd0, resp_table}, 64'hA8A8A800);
        chk("rst_resweep_pass", {63'd0, pass}, 64'd1);

        // SETTLE=0 instance: vec advances every 2 cycles, busy 64 cycles
        @(negedge clock) s0_start = 1'b1;
        @(negedge clock) s0_start = 1'b0;
        bcyc = 0;
        dcnt = 0;
        for (int i = 0; i < 72; i++) begin
            if (s0_busy) bcyc++;
            if (s0_done) dcnt++;
            if (i == 0 || i == 2 || i == 4 || i == 11)
                chk($sformatf("s0_vec_cycle%0d", i), {59'd0, s0_vec}, 64'(i / 2));
            @(negedge clock);
        end
        chk("s0_busy_cycles", 64'(bcyc), 64'd64);
        chk("s0_done_pulses", 64'(dcnt), 64'd1);
        chk("s0_table", {32'd0, s0_table}, 64'hA8A8A800);
        chk("s0_pass", {62'd0, s0_pass, s0_aborted}, 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/response engine for small combinational blocks: exhaustively sweeps an N_IN-bit input vector, samples the block's 1-bit response per vector and builds the captured truth table.
- Compares each sample against a parameterised expected table and reports mismatch count and first failing index.
- Sits beside a combinational module under test for on-chip self-check; it is the driving and capturing end, the counterpart of the block it exercises.

Parameters:
- N_IN, 5, width of the driven input vector; the sweep covers 2**N_IN vectors.
- SETTLE, 2, extra hold cycles per vector before sampling; each vector is held SETTLE+1 cycles, SETTLE >= 0.
- EXPECT, 32'hA8A8A800, expected response table, width 2**N_IN; bit i is the expected resp for vec==i.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled request to begin a sweep; honoured only in IDLE.
- abort  in  1  terminates an in-progress sweep.
- resp  in  1  response of the block under test.
- vec  out  N_IN  applied input vector; bit N_IN-1 is the first-listed input.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse on normal sweep completion.
- aborted  out  1  sticky; set by abort, cleared by the next accepted start.
- table  out  2**N_IN  captured responses; bit i = resp sampled for vec==i.
- err_count  out  N_IN+1  number of mismatches against EXPECT.
- first_err  out  N_IN  index of the first mismatch; valid when err_count != 0.
- pass  out  1  high in DONE and afterwards iff err_count==0; cleared on start, abort and reset.

Behaviour:
- Reset (asynchronous, reset_b low): state=IDLE; vec, table, err_count, first_err = 0; busy, done, aborted, pass = 0.
- Reset takes effect immediately in any state, including mid-sweep, and discards partial results.
- FSM states: IDLE, HOLD, SAMPLE, DONE.
- IDLE:
  - start==1 at a rising edge: next cycle state=HOLD, busy=1, vec=0, hold counter=0.
  - table, err_count, first_err, aborted and pass are cleared on the same edge.
- HOLD:
  - Counter increments each cycle.
  - When counter==SETTLE (immediately if SETTLE==0), go to SAMPLE on the next edge. The "next edge" sampling is fixed behaviour, so vec is held exactly SETTLE+1 cycles in HOLD plus 1 cycle in SAMPLE.
- SAMPLE (one cycle):
  - table[vec] <= resp.
  - If resp != EXPECT[vec]: err_count += 1; if err_count was 0, first_err <= vec.
  - If vec == 2**N_IN-1: go to DONE.
  - Else: vec <= vec+1, counter <= 0, go to HOLD.
- DONE (one cycle): done=1, busy=0, pass=(err_count==0), vec held at last value; then IDLE.
- Timing: busy stays high for 2**N_IN*(SETTLE+2) cycles. With defaults that is 128 cycles, and done pulses in the following cycle.
- start while busy or in DONE is ignored; no queuing. start held high continuously re-triggers a new sweep from IDLE.
- abort:
  - In HOLD or SAMPLE: next state IDLE, busy=0, aborted=1, no done, vec=0.
  - table/err_count keep their partial contents.
  - If abort and the final SAMPLE coincide, abort wins: no done, and that sample is not written.
  - abort in IDLE or DONE has no effect.
- err_count saturates by construction: its maximum 2**N_IN fits in N_IN+1 bits.

Test Plan:
- Default EXPECT, resp driven by the reference function F=(a|b)&(c|d)&e of vec (vec={a,b,c,d,e}), start pulsed once -> busy high 128 cycles, done single pulse, table==32'hA8A8A800, err_count==0, pass==1.
- resp stuck at 0 -> table==0, err_count==9, first_err==11, pass==0.
- resp = F with vec==19 inverted -> err_count==1, first_err==19, table==32'hA8A0A800.
- abort asserted in the cycle vec==5 is in SAMPLE -> next cycle busy==0, aborted==1, no done, table bits [4:0] valid, bit 5 not written.
- reset_b dropped mid-sweep at vec==17 -> all outputs 0 asynchronously; subsequent start gives a full correct sweep.
- start pulsed while busy and during the done cycle -> ignored; SETTLE=0 build -> vec advances every 2 cycles, busy 64 cycles.
